// File: rtl/divu_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional DIVU_EARLY_OUT_EN: finishes at load when dividend < divisor.
module divu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    // The top bit of the WIDTH+1-bit partial remainder is always 0 after a
    // restoring step, so only the low WIDTH bits are stored.
    logic [WIDTH-1:0] part_rem;
    logic [CNT_W-1:0] counter;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             accept;
    logic [WIDTH-1:0] new_rem;
    logic [WIDTH-1:0] new_quo;

    always_comb begin
        shifted = {part_rem, dividend[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        accept  = ~diff[WIDTH];
        new_rem = accept ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        new_quo = {dividend[WIDTH-2:0], accept};
    end

    assign busy = (state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dividend    <= '0;
            divisor     <= '0;
            part_rem    <= '0;
            counter     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_FIN: begin
                    if (start) begin
                        dividend <= dataA;
                        divisor  <= dataB;
                        part_rem <= '0;
                        counter  <= '0;
                        if (dataB == '0) begin
                            state       <= S_FIN;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dataA;
                            div_by_zero <= 1'b1;
                        end
`ifdef DIVU_EARLY_OUT_EN
                        else if (dataA < dataB) begin
                            state       <= S_FIN;
                            done        <= 1'b1;
                            quotient    <= '0;
                            remainder   <= dataA;
                            div_by_zero <= 1'b0;
                        end
`endif
                        else begin
                            state       <= S_RUN;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    part_rem <= new_rem;
                    dividend <= new_quo;
                    counter  <= counter + 1'b1;
                    if (counter == LAST) begin
                        state     <= S_FIN;
                        done      <= 1'b1;
                        quotient  <= new_quo;
                        remainder <= new_rem;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_unit.sv
module tb_divu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int nvec = 0;
  int nerr = 0;
  int lat, lat1;
  bit saw_busy;

`ifdef DIVU_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  divu_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .dataA(dataA), .dataB(dataB),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    dataA = a;
    dataB = b;
  endtask

  task automatic wait_done(output int n, output bit sb);
    n  = 0;
    sb = 1'b0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (busy) sb = 1'b1;
    end while (!done && n <= 100);
    nvec++;
    if (!done) begin
      nerr++;
      $error("FAIL wait_done expired after %0d cycles without done", n);
    end
  endtask

  initial begin
    rst = 1'b1;
    #12;
    chk("por_busy", busy, 1'b0);
    chk("por_done", done, 1'b0);
    chk("por_quo", quotient, 32'd0);
    chk("por_rem", remainder, 32'd0);
    chk("por_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd100, 32'd7);
    wait_done(lat, saw_busy);
    chk("lat_100_7", lat, 33);
    chk("quo_100_7", quotient, 32'd14);
    chk("rem_100_7", remainder, 32'd2);
    chk("dbz_100_7", div_by_zero, 1'b0);
    @(negedge clk);
    chk("done_pulse_once", done, 1'b0);
    chk("hold_quo", quotient, 32'd14);

    #2 rst = 1'b1;
    #1;
    chk("arst_quo", quotient, 32'd0);
    chk("arst_rem", remainder, 32'd0);
    chk("arst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(lat, saw_busy);
    chk("lat_max_1", lat, 33);
    chk("quo_max_1", quotient, 32'hFFFF_FFFF);
    chk("rem_max_1", remainder, 32'd0);
    issue(32'd10, 32'd3);
    wait_done(lat, saw_busy);
    chk("lat_b2b", lat, 33);
    chk("quo_10_3", quotient, 32'd3);
    chk("rem_10_3", remainder, 32'd1);

    @(negedge clk);
    issue(32'd55, 32'd0);
    wait_done(lat, saw_busy);
    chk("lat_dbz", lat, 1);
    chk("busy_dbz", saw_busy, 1'b0);
    chk("quo_dbz", quotient, 32'hFFFF_FFFF);
    chk("rem_dbz", remainder, 32'd55);
    chk("flag_dbz", div_by_zero, 1'b1);

    @(negedge clk);
    issue(32'd5, 32'd9);
    wait_done(lat, saw_busy);
    chk("lat_5_9", lat, EARLY_LAT);
    chk("quo_5_9", quotient, 32'd0);
    chk("rem_5_9", remainder, 32'd5);
    chk("dbz_clr", div_by_zero, 1'b0);

    @(negedge clk);
    issue(32'd1000, 32'd10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    issue(32'd9, 32'd3);
    wait_done(lat1, saw_busy);
    chk("lat_ignore", lat1 + 5, 33);
    chk("quo_ignore", quotient, 32'd100);
    chk("rem_ignore", remainder, 32'd0);

    @(negedge clk);
    issue(32'd1000, 32'd10);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("busy_mid", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_quo", quotient, 32'd0);
    chk("abort_busy", busy, 1'b0);
    #1 rst = 1'b0;
    saw_busy = 1'b0;
    lat = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) lat++;
      if (busy) saw_busy = 1'b1;
    end
    chk("abort_no_done", lat, 0);
    chk("abort_idle", saw_busy, 1'b0);
    chk("abort_rem", remainder, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
